cpu_move_picker: RTL and testbench
==================================

# cpu_move_picker

Computer-opponent move selector for the 5x5 game board. It sits directly downstream of the random number generator. It drives the generator's `numGenerate` strobe, captures two draws in the range 0-4 as a row and a column, and rejects cells that are already occupied. If the retry budget runs out, it falls back to a deterministic scan. The chosen cell goes to the game controller through a start/done handshake.

## Interface
- `MAX_TRIES`, default 15: number of random (row, col) attempts before falling back to the scan; must be at least 1.
- `TRY_W`, default 4: width of the try counter; must satisfy 2^TRY_W > MAX_TRIES.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: single-cycle request for a move; sampled only in IDLE.
- `occupied` in 25: board occupancy, bit index = row*5+col; 1 means taken.
- `ran_num` in 3: registered output of the random number generator.
- `gen_req` out 1: drives the generator's `numGenerate`.
- `busy` out 1: high from the cycle after an accepted start until the cycle of `done`, inclusive.
- `done` out 1: one-cycle pulse; result outputs are valid in that cycle and held until the next accepted start.
- `cell_row` out 3: chosen row, 0-4.
- `cell_col` out 3: chosen column, 0-4.
- `cell_idx` out 5: row*5+col, 0-24.
- `board_full` out 1: set together with `done` when no free cell exists.
- `used_scan` out 1: set together with `done` when the result came from the fallback scan.

## Operation
- States: IDLE, REQ_ROW, CAP_ROW, REQ_COL, CAP_COL, CHECK, SCAN, DONE.
- IDLE:
  - On `start`, latch `occupied` into `occ_q`, clear the try counter, and clear `board_full` and `used_scan`.
  - If all 25 bits of `occupied` are 1, go to DONE with `board_full`=1; `cell_*` keep their previous values.
  - Otherwise go to REQ_ROW.
- REQ_ROW: `gen_req`=1 for exactly this cycle, then go to CAP_ROW.
- CAP_ROW:
  - Row register = `ran_num`.
  - If `ran_num` > 4, increment the try counter and return to REQ_ROW, or go to SCAN if the budget is spent.
  - Otherwise go to REQ_COL.
- REQ_COL: `gen_req`=1, then go to CAP_COL.
- CAP_COL:
  - Column register = `ran_num`.
  - If `ran_num` > 4, treat as an out-of-range draw: same retry handling as CAP_ROW.
  - Otherwise go to CHECK.
- CHECK:
  - Compute idx = row*5+col as an unsigned 5-bit value; maximum is 24, no overflow.
  - If `occ_q[idx]`=0, go to DONE.
  - Otherwise increment the try counter; go to REQ_ROW if tries < MAX_TRIES, else go to SCAN.
- SCAN:
  - The scan index starts at 0 and advances by 1 per cycle.
  - At the first free `occ_q` bit, set row = idx/5, col = idx%5, set `used_scan`=1, and go to DONE.
  - The scan cannot miss, because fullness was already excluded in IDLE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Board changes while busy are ignored; only `occ_q` is used.
- `start` while busy is ignored and is not queued.

## Timing
- Reset values: `gen_req`, `busy`, `done`, `board_full` and `used_scan` = 0; `cell_row`, `cell_col` and `cell_idx` = 0; state = IDLE.
- The generator updates `ranNum` on the edge where it samples `numGenerate`=1. The CAP_* states therefore read `ran_num` in the cycle after `gen_req`.
- Since the generator's LFSR advances every clock, the row and column draws differ.
- Latency is counted from the edge that samples `start` (cycle 0):
  - First-try success: `done` in cycle 6.
  - Each rejected attempt adds 5 cycles; an out-of-range row draw adds 2 cycles.
  - Full board: `done` in cycle 2.
  - Scan fallback: entry cycle plus one cycle per index up to the first free index k, then DONE.
- Reset assertion mid-operation forces IDLE immediately. Outputs return to their reset values and there is no `done` pulse.
- `gen_req` is never high outside REQ_ROW and REQ_COL.

## Test plan
- **Empty board:** reset low for 3 cycles, then release; pulse `start`; the model returns 2 then 3.
  - Required: `gen_req` high in cycles 1 and 3; `done` in cycle 6 with row=2, col=3, idx=13.
  - Also required: `busy` high in cycles 1-6; `used_scan`=0.
- **Retry:** `occupied` bit 13 set; the model returns (2,3), then (0,4).
  - Required: `done` in cycle 11 with idx=4.
- **Out-of-range draw:** the model returns 7 for the row, then 1, 1.
  - Required: the 7 is rejected; `done` in cycle 8 with idx=6.
- **Scan fallback:** `occupied`=25'h1FFFFF7 (only idx 3 free); the model always returns (0,0).
  - Required: 15 attempts, then the scan; `done` with row=0, col=3, `used_scan`=1.
- **Full board:** `occupied`=25'h1FFFFFF.
  - Required: `done` in cycle 2, `board_full`=1, `gen_req` never asserted.
- **Reset mid-operation and start while busy:**
  - Assert reset in cycle 4 of a pick: required no `done` and all outputs at 0.
  - Pulse `start` again while busy: required no effect on the result or on latency.

Source files
------------

// File: rtl/cpu_move_picker.sv
// cpu_move_picker
// Computer-opponent move selector for the 5x5 board. Requests two draws from
// the random number generator (row, then column), rejects out-of-range draws
// and occupied cells, and falls back to a linear scan once the retry budget
// is spent. The result is reported with a one-cycle done pulse.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low
//   start       one-cycle move request, sampled only when idle
//   occupied    board occupancy, bit row*5+col, 1 = taken
//   ran_num     registered output of the random number generator
//   gen_req     numGenerate strobe to the generator
//   busy        high from the cycle after an accepted start through done
//   done        one-cycle result-valid pulse
//   cell_row    chosen row 0-4 (held until the next result)
//   cell_col    chosen column 0-4
//   cell_idx    row*5+col
//   board_full  with done: no free cell existed
//   used_scan   with done: result came from the fallback scan
module cpu_move_picker #(
    parameter int MAX_TRIES = 15,
    parameter int TRY_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [24:0] occupied,
    input  logic [2:0]  ran_num,
    output logic        gen_req,
    output logic        busy,
    output logic        done,
    output logic [2:0]  cell_row,
    output logic [2:0]  cell_col,
    output logic [4:0]  cell_idx,
    output logic        board_full,
    output logic        used_scan
);

    typedef enum logic [2:0] {
        IDLE, REQ_ROW, CAP_ROW, REQ_COL, CAP_COL, CHECK, SCAN, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [24:0]        occ_q, occ_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic               full_q, full_d;
    logic [4:0]         scan_idx_q, scan_idx_d;
    logic [2:0]         scan_row_q, scan_row_d;
    logic [2:0]         scan_col_q, scan_col_d;
    logic               gen_req_q, gen_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         cell_row_q, cell_row_d;
    logic [2:0]         cell_col_q, cell_col_d;
    logic [4:0]         cell_idx_q, cell_idx_d;
    logic               board_full_q, board_full_d;
    logic               used_scan_q, used_scan_d;

    logic [4:0]         try_idx;
    logic               retry_left;

    // row*5 + col as (row<<2) + row + col; at most 24, fits in 5 bits.
    assign try_idx = {row_q, 2'b00} + {2'b00, row_q} + {2'b00, col_q};

    // The failing attempt is number tries_q+1; another one is allowed only
    // while that stays below the budget.
    assign retry_left = (tries_q < TRY_W'(MAX_TRIES - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned (which would infer a latch).
        state_d      = state_q;
        occ_d        = occ_q;
        tries_d      = tries_q;
        row_d        = row_q;
        col_d        = col_q;
        full_d       = full_q;
        scan_idx_d   = scan_idx_q;
        scan_row_d   = scan_row_q;
        scan_col_d   = scan_col_q;
        cell_row_d   = cell_row_q;
        cell_col_d   = cell_col_q;
        cell_idx_d   = cell_idx_q;
        board_full_d = board_full_q;
        used_scan_d  = used_scan_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    occ_d        = occupied;
                    tries_d      = '0;
                    board_full_d = 1'b0;
                    used_scan_d  = 1'b0;
                    // A full board takes one pass through CHECK before DONE,
                    // which resolves it without touching the generator.
                    full_d       = &occupied;
                    state_d      = (&occupied) ? CHECK : REQ_ROW;
                end
            end
            REQ_ROW: state_d = CAP_ROW;
            CAP_ROW: begin
                row_d = ran_num;
                if (ran_num > 3'd4) begin
                    tries_d = tries_q + 1'b1;
                    state_d = retry_left ? REQ_ROW : SCAN;
                end else begin
                    state_d = REQ_COL;
                end
            end
            REQ_COL: state_d = CAP_COL;
            CAP_COL: begin
                col_d = ran_num;
                if (ran_num > 3'd4) begin
                    tries_d = tries_q + 1'b1;
                    state_d = retry_left ? REQ_ROW : SCAN;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (full_q) begin
                    board_full_d = 1'b1;
                    state_d      = DONE;
                end else if (!occ_q[try_idx]) begin
                    cell_row_d = row_q;
                    cell_col_d = col_q;
                    cell_idx_d = try_idx;
                    state_d    = DONE;
                end else begin
                    tries_d = tries_q + 1'b1;
                    state_d = retry_left ? REQ_ROW : SCAN;
                end
            end
            SCAN: begin
                // Row and column track the index as counters, avoiding a
                // divide-by-5; the walk always ends because a full board
                // never reaches this state.
                if (!occ_q[scan_idx_q]) begin
                    cell_row_d  = scan_row_q;
                    cell_col_d  = scan_col_q;
                    cell_idx_d  = scan_idx_q;
                    used_scan_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    scan_idx_d = scan_idx_q + 5'd1;
                    if (scan_col_q == 3'd4) begin
                        scan_col_d = 3'd0;
                        scan_row_d = scan_row_q + 3'd1;
                    end else begin
                        scan_col_d = scan_col_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every entry into SCAN starts from cell 0.
        if (state_d == SCAN && state_q != SCAN) begin
            scan_idx_d = '0;
            scan_row_d = '0;
            scan_col_d = '0;
        end

        // Handshake outputs are registered decodes of the next state.
        gen_req_d = (state_d == REQ_ROW) || (state_d == REQ_COL);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            tries_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            full_q       <= 1'b0;
            scan_idx_q   <= '0;
            scan_row_q   <= '0;
            scan_col_q   <= '0;
            gen_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cell_row_q   <= '0;
            cell_col_q   <= '0;
            cell_idx_q   <= '0;
            board_full_q <= 1'b0;
            used_scan_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            occ_q        <= occ_d;
            tries_q      <= tries_d;
            row_q        <= row_d;
            col_q        <= col_d;
            full_q       <= full_d;
            scan_idx_q   <= scan_idx_d;
            scan_row_q   <= scan_row_d;
            scan_col_q   <= scan_col_d;
            gen_req_q    <= gen_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cell_row_q   <= cell_row_d;
            cell_col_q   <= cell_col_d;
            cell_idx_q   <= cell_idx_d;
            board_full_q <= board_full_d;
            used_scan_q  <= used_scan_d;
        end
    end

    assign gen_req    = gen_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cell_row   = cell_row_q;
    assign cell_col   = cell_col_q;
    assign cell_idx   = cell_idx_q;
    assign board_full = board_full_q;
    assign used_scan  = used_scan_q;

endmodule

// File: tb/tb_cpu_move_picker.sv
// Testbench for cpu_move_picker: a scripted random-number source, an
// attempt-level model of the pick, and a per-cycle compare process.
module tb_cpu_move_picker;

    localparam int MAX_TRIES = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [24:0] occupied;
    logic [2:0]  ran_num;
    logic        gen_req, busy, done;
    logic [2:0]  cell_row, cell_col;
    logic [4:0]  cell_idx;
    logic        board_full, used_scan;

    cpu_move_picker #(.MAX_TRIES(MAX_TRIES), .TRY_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .occupied(occupied),
        .ran_num(ran_num), .gen_req(gen_req), .busy(busy), .done(done),
        .cell_row(cell_row), .cell_col(cell_col), .cell_idx(cell_idx),
        .board_full(board_full), .used_scan(used_scan)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scripted generator: each sampled gen_req loads the next scripted draw;
    // an exhausted script keeps returning 0.
    int script[$];
    int gen_q[$];
    always @(posedge clk) begin
        if (gen_req) begin
            if (gen_q.size() != 0) ran_num <= 3'(gen_q.pop_front());
            else                   ran_num <= 3'd0;
        end
    end

    // Model state: expected result of the current pick.
    bit exp_gen[0:511];
    int exp_done, exp_row, exp_col, exp_idx, exp_full, exp_scan;
    int prev_row = 0, prev_col = 0, prev_idx = 0;

    function automatic int draw(input int i);
        return (i < script.size()) ? script[i] : 0;
    endfunction

    // Walks the pick attempt by attempt. 'base' is the cycle before the
    // attempt's row request; a full attempt spans 5 cycles, a bad row draw 2,
    // a bad column draw 4.
    task automatic model_pick(input logic [24:0] occ);
        int base = 0, tries = 0, ptr = 0, r, c, k;
        bit resolved = 0, do_scan = 0;
        for (int i = 0; i < 512; i++) exp_gen[i] = 0;
        exp_full = 0; exp_scan = 0;
        exp_row = prev_row; exp_col = prev_col; exp_idx = prev_idx;
        if (occ == 25'h1FFFFFF) begin
            exp_done = 2; exp_full = 1; resolved = 1;
        end
        while (!resolved && !do_scan) begin
            r = draw(ptr++); exp_gen[base + 1] = 1;
            if (r > 4) begin
                tries++; base += 2;
                if (tries == MAX_TRIES) do_scan = 1;
                continue;
            end
            c = draw(ptr++); exp_gen[base + 3] = 1;
            if (c > 4) begin
                tries++; base += 4;
                if (tries == MAX_TRIES) do_scan = 1;
                continue;
            end
            if (!occ[r*5 + c]) begin
                exp_done = base + 6; exp_row = r; exp_col = c; exp_idx = r*5 + c;
                resolved = 1;
            end else begin
                tries++; base += 5;
                if (tries == MAX_TRIES) do_scan = 1;
            end
        end
        if (do_scan) begin
            k = 0;
            while (occ[k]) k++;
            exp_done = base + k + 2;
            exp_row = k / 5; exp_col = k % 5; exp_idx = k; exp_scan = 1;
        end
    endtask

    // Compare process: cycle 0 is the cycle in which start is high.
    bit mon_en = 0;
    int mon_cyc;
    int obs_done;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            check($sformatf("gen_req c%0d", mon_cyc), gen_req, int'(exp_gen[mon_cyc]));
            check($sformatf("busy c%0d", mon_cyc), busy,
                  (mon_cyc >= 1 && mon_cyc <= exp_done) ? 1 : 0);
            check($sformatf("done c%0d", mon_cyc), done, (mon_cyc == exp_done) ? 1 : 0);
            if (done && obs_done < 0) obs_done = mon_cyc;
            if (mon_cyc >= 1) begin
                check($sformatf("board_full c%0d", mon_cyc), board_full,
                      (mon_cyc >= exp_done) ? exp_full : 0);
                check($sformatf("used_scan c%0d", mon_cyc), used_scan,
                      (mon_cyc >= exp_done) ? exp_scan : 0);
            end
            if (mon_cyc >= exp_done) begin
                check($sformatf("cell_row c%0d", mon_cyc), cell_row, exp_row);
                check($sformatf("cell_col c%0d", mon_cyc), cell_col, exp_col);
                check($sformatf("cell_idx c%0d", mon_cyc), cell_idx, exp_idx);
            end
            if (mon_cyc >= exp_done + 1) mon_en = 0;
        end
    end

    // One pick: model it, pulse start, optionally pulse start again while
    // busy (extra_start > 0) and/or scramble the live board after start.
    task automatic run_pick(input logic [24:0] occ, input int extra_start,
                            input bit scramble);
        gen_q = script;
        model_pick(occ);
        obs_done = -1;
        @(posedge clk); #1;
        occupied = occ; start = 1'b1; mon_cyc = -1; mon_en = 1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) occupied = 25'h1FFFFFF;
        if (extra_start > 0) begin
            repeat (extra_start - 1) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 400 && mon_en; i++) @(posedge clk);
        if (mon_en) begin
            check("pick_timeout", 1, 0);
            mon_en = 0;
        end
        prev_row = exp_row; prev_col = exp_col; prev_idx = exp_idx;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; occupied = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst gen_req", gen_req, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cell_idx", cell_idx, 0);
        check("rst board_full", board_full, 0);
        check("rst used_scan", used_scan, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Empty board, with a second start during the pick.
        script = '{2, 3};
        run_pick(25'h0, 3, 0);
        check("empty done_cycle", obs_done, 6);
        check("empty idx", cell_idx, 13);
        check("empty row", cell_row, 2);
        check("empty col", cell_col, 3);

        // Retry: (2,3) taken, then (0,4); live board changes are ignored.
        script = '{2, 3, 0, 4};
        run_pick(25'h0002000, 0, 1);
        check("retry done_cycle", obs_done, 11);
        check("retry idx", cell_idx, 4);

        // Out-of-range row draw.
        script = '{7, 1, 1};
        run_pick(25'h0, 0, 0);
        check("oor done_cycle", obs_done, 8);
        check("oor idx", cell_idx, 6);

        // Scan fallback: only idx 3 free, generator always returns 0.
        script = '{};
        run_pick(25'h1FFFFF7, 0, 0);
        check("scan row", cell_row, 0);
        check("scan col", cell_col, 3);
        check("scan used_scan", used_scan, 1);

        // Full board: cells keep the previous result.
        script = '{};
        run_pick(25'h1FFFFFF, 0, 0);
        check("full done_cycle", obs_done, 2);
        check("full board_full", board_full, 1);
        check("full idx held", cell_idx, 3);

        // Reset asserted in cycle 4 of a pick.
        script = '{2, 3};
        gen_q = script;
        @(posedge clk); #1 occupied = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst gen_req", gen_req, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst cell_row", cell_row, 0);
        check("midrst cell_col", cell_col, 0);
        check("midrst cell_idx", cell_idx, 0);
        check("midrst board_full", board_full, 0);
        check("midrst used_scan", used_scan, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        begin
            int seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (done || busy || gen_req) seen++;
            end
            check("midrst no_activity", seen, 0);
        end
        prev_row = 0; prev_col = 0; prev_idx = 0;

        // Recovery pick at the far corner cell.
        script = '{4, 4};
        run_pick(25'h0, 0, 0);
        check("corner done_cycle", obs_done, 6);
        check("corner idx", cell_idx, 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
